// File: rtl/conv_dnn_frame_buffer.sv
// Ping-pong frame buffer between the conv/pool stage and the dense stage.
// Writes pixel-major beats (PE channels each, requantised), replays channel-major (OutLanes pixels each).
module conv_dnn_frame_buffer #(
   parameter int BitSize    = 32,
   parameter int OutBitSize = 16,
   parameter int Shift      = 8,
   parameter int NumK       = 4,
   parameter int PE         = 2,
   parameter int NumIn      = 4,
   parameter int OutLanes   = 2,
   localparam int CH_W      = (NumK > 1) ? $clog2(NumK) : 1
) (
   input  logic                                 clk,
   input  logic                                 res_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [PE-1:0][BitSize-1:0]           in_data,
   input  logic                                 in_last,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [OutLanes-1:0][OutBitSize-1:0]  out_data,
   output logic [CH_W-1:0]                      out_ch,
   output logic                                 out_last_ch,
   output logic                                 out_last_frame,
   output logic                                 err
);

   // Read FSM
   // state       | meaning
   // ST_IDLE     | no full bank to drain, output register empty
   // ST_PREFETCH | loading beat 0 of rd_bank into the output register
   // ST_STREAM   | output register holds a valid beat; on the final handshake either
   //             | chains straight into beat 0 of the other (full) bank or goes idle

   localparam int KB_N   = NumK / PE;
   localparam int KB_W   = (KB_N > 1) ? $clog2(KB_N) : 1;
   localparam int P_W    = (NumIn > 1) ? $clog2(NumIn) : 1;
   localparam int OB_N   = NumIn / OutLanes;
   localparam int OB_W   = (OB_N > 1) ? $clog2(OB_N) : 1;
   localparam int WORDS  = NumK * NumIn;
   localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic signed [BitSize-1:0] Q_MAX =
      {{(BitSize-OutBitSize+1){1'b0}}, {(OutBitSize-1){1'b1}}};
   localparam logic signed [BitSize-1:0] Q_MIN =
      {{(BitSize-OutBitSize+1){1'b1}}, {(OutBitSize-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREFETCH,
      ST_STREAM
   } rd_state_t;

   logic [OutBitSize-1:0] mem [2][WORDS];
   logic [1:0]            full;
   logic                  wr_bank;
   logic                  rd_bank;
   logic [KB_W-1:0]       wr_kb;
   logic [P_W-1:0]        wr_p;
   logic                  wr_fire;
   logic                  wr_final;
   logic [ADDR_W-1:0]     wr_base;

   rd_state_t             rd_state;
   rd_state_t             rd_state_nxt;
   logic [OB_W-1:0]       rd_ob;
   logic                  out_hs;
   logic                  frame_done;
   logic                  ld_en;
   logic                  ld_bank;
   logic [CH_W-1:0]       ld_ch;
   logic [OB_W-1:0]       ld_ob;
   logic [ADDR_W-1:0]     ld_base;

   // Floor shift then clamp to the signed output range.
   function automatic logic [OutBitSize-1:0] quant(input logic [BitSize-1:0] v);
      logic signed [BitSize-1:0] q;
      q = $signed(v) >>> Shift;
      if (q > Q_MAX) begin
         q = Q_MAX;
      end else if (q < Q_MIN) begin
         q = Q_MIN;
      end
      return q[OutBitSize-1:0];
   endfunction

   assign in_ready   = !full[wr_bank];
   assign wr_fire    = in_valid && in_ready;
   assign wr_final   = (wr_kb == KB_W'(KB_N-1)) && (wr_p == P_W'(NumIn-1));
   assign wr_base    = ADDR_W'(wr_kb) * ADDR_W'(PE*NumIn) + ADDR_W'(wr_p);
   assign out_hs     = out_valid && out_ready;
   assign frame_done = (rd_state == ST_STREAM) && out_hs && out_last_frame;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         wr_kb   <= '0;
         wr_p    <= '0;
         wr_bank <= 1'b0;
         err     <= 1'b0;
      end else if (wr_fire) begin
         if (in_last != wr_final) begin
            err <= 1'b1;
         end
         if (wr_kb == KB_W'(KB_N-1)) begin
            wr_kb <= '0;
            wr_p  <= wr_final ? '0 : wr_p + P_W'(1);
         end else begin
            wr_kb <= wr_kb + KB_W'(1);
         end
         if (wr_final) begin
            wr_bank <= ~wr_bank;
         end
      end
   end

   // Lane l of a write beat is channel wr_kb*PE+l, stored at [k][p].
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int l = 0; l < PE; l++) begin
            mem[wr_bank][wr_base + ADDR_W'(l*NumIn)] <= quant(in_data[l]);
         end
      end
   end

   // The writer only touches a non-full bank and the reader only drains a full one,
   // so a set and a clear in the same cycle always hit different banks.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         full <= '0;
      end else begin
         if (wr_fire && wr_final) begin
            full[wr_bank] <= 1'b1;
         end
         if (frame_done) begin
            full[rd_bank] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         rd_state <= ST_IDLE;
      end else begin
         rd_state <= rd_state_nxt;
      end
   end

   always_comb begin
      rd_state_nxt = rd_state;
      ld_en        = 1'b0;
      ld_bank      = rd_bank;
      ld_ch        = '0;
      ld_ob        = '0;
      case (rd_state)
         ST_IDLE: begin
            if (full[rd_bank]) begin
               rd_state_nxt = ST_PREFETCH;
            end
         end
         ST_PREFETCH: begin
            ld_en        = 1'b1;
            rd_state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            if (out_hs) begin
               if (!out_last_frame) begin
                  ld_en = 1'b1;
                  if (out_last_ch) begin
                     ld_ch = out_ch + CH_W'(1);
                  end else begin
                     ld_ch = out_ch;
                     ld_ob = rd_ob + OB_W'(1);
                  end
               end else if (full[~rd_bank]) begin
                  ld_en   = 1'b1;
                  ld_bank = ~rd_bank;
               end else begin
                  rd_state_nxt = ST_IDLE;
               end
            end
         end
         default: rd_state_nxt = ST_IDLE;
      endcase
   end

   assign ld_base = ADDR_W'(ld_ch) * ADDR_W'(NumIn) + ADDR_W'(ld_ob) * ADDR_W'(OutLanes);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_ch         <= '0;
         rd_ob          <= '0;
         out_last_ch    <= 1'b0;
         out_last_frame <= 1'b0;
         rd_bank        <= 1'b0;
      end else begin
         if (ld_en) begin
            out_valid <= 1'b1;
            for (int j = 0; j < OutLanes; j++) begin
               out_data[j] <= mem[ld_bank][ld_base + ADDR_W'(j)];
            end
            out_ch         <= ld_ch;
            rd_ob          <= ld_ob;
            out_last_ch    <= (ld_ob == OB_W'(OB_N-1));
            out_last_frame <= (ld_ob == OB_W'(OB_N-1)) && (ld_ch == CH_W'(NumK-1));
         end else if (frame_done) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_ch         <= '0;
            rd_ob          <= '0;
            out_last_ch    <= 1'b0;
            out_last_frame <= 1'b0;
         end
         if (frame_done) begin
            rd_bank <= ~rd_bank;
         end
      end
   end

endmodule

// File: tb/tb_conv_dnn_frame_buffer.sv
// Self-checking bench for conv_dnn_frame_buffer: a frame-level model (2-D array per frame,
// queue of expected output beats) checks every output handshake plus timing/hold/err behaviour.
module tb_conv_dnn_frame_buffer;

   localparam int NK = 4;
   localparam int PE = 2;
   localparam int NI = 4;
   localparam int OL = 2;
   localparam int BEATS_IN = NK*NI/PE;
   localparam longint DIV = 256;

   logic                clk;
   logic                res_n;
   logic                in_valid;
   logic                in_ready;
   logic [PE-1:0][31:0] in_data;
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   logic [OL-1:0][15:0] out_data;
   logic [1:0]          out_ch;
   logic                out_last_ch;
   logic                out_last_frame;
   logic                err;

   conv_dnn_frame_buffer dut (
      .clk            (clk),
      .res_n          (res_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_last        (in_last),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_ch         (out_ch),
      .out_last_ch    (out_last_ch),
      .out_last_frame (out_last_frame),
      .err            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [31:0] data;
      int          ch;
      bit          lc;
      bit          lf;
   } beat_t;

   beat_t       expq[$];
   logic [15:0] fr [NK][NI];
   int          pos = 0;
   bit          err_exp = 0;
   logic [31:0] specials [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                 32'h0000_0180, 32'hFFFF_FE80};

   int n_checks = 0;
   int n_err    = 0;

   int  cons_mode = 0;
   int  in_hs_cnt = 0;
   int  out_hs_cnt = 0;
   int  hs8_cyc = -1;
   int  ready_rise_cyc = -1;
   bit  rdy_prev = 1;
   int  last_acc_cyc = 0;
   int  first_valid_cyc = 0;
   int  idle_cnt = 0;
   bit  prod_busy = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_q(input logic [31:0] v);
      longint sv;
      longint q;
      sv = longint'($signed(v));
      if (sv >= 0) q = sv / DIV;
      else         q = -((-sv + DIV - 1) / DIV);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return 16'(q);
   endfunction

   function automatic logic [31:0] gen(input int kind, input int k, input int p, input int idx);
      int s;
      if (kind == 0) return 32'((16*k + p) << 8);
      if (kind == 1) return $urandom();
      s = idx % 6;
      if (s < 5) return specials[s];
      return $urandom();
   endfunction

   task automatic model_accept(input logic [PE-1:0][31:0] d, input logic last);
      beat_t e;
      int p;
      int kb;
      p  = pos / (NK/PE);
      kb = pos % (NK/PE);
      for (int l = 0; l < PE; l++) fr[kb*PE + l][p] = ref_q(d[l]);
      if (last != (pos == BEATS_IN-1)) err_exp = 1;
      pos++;
      if (pos == BEATS_IN) begin
         for (int k = 0; k < NK; k++) begin
            for (int b = 0; b < NI/OL; b++) begin
               e.data = {fr[k][b*OL+1], fr[k][b*OL]};
               e.ch   = k;
               e.lc   = (b == NI/OL-1);
               e.lf   = (b == NI/OL-1) && (k == NK-1);
               expq.push_back(e);
            end
         end
         pos = 0;
      end
   endtask

   task automatic put_beats(input int n, input int kind, input logic [7:0] lmask);
      bit acc;
      bit rdy;
      int waited;
      int p;
      int kb;
      for (int i = 0; i < n; i++) begin
         p  = pos / (NK/PE);
         kb = pos % (NK/PE);
         for (int l = 0; l < PE; l++) in_data[l] = gen(kind, kb*PE + l, p, pos*PE + l);
         in_last  = lmask[pos];
         in_valid = 1'b1;
         acc = 0;
         waited = 0;
         while (!acc && waited < 400) begin
            rdy = in_ready;
            if (rdy && !rdy_prev && ready_rise_cyc < 0) ready_rise_cyc = cyc;
            rdy_prev = rdy;
            @(posedge clk);
            if (rdy) acc = 1;
            @(negedge clk);
            waited++;
         end
         if (!acc) begin
            chk("in_accept_timeout", 64'(waited), 0);
         end else begin
            model_accept(in_data, in_last);
            in_hs_cnt++;
            last_acc_cyc = cyc;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      prod_busy = 0;
   endtask

   task automatic wait_drain();
      bit done;
      done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         #2;
         if (!prod_busy && expq.size() == 0 && !out_valid) done = 1;
      end
      if (!done) chk("drain_timeout", 64'(expq.size()), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"},  out_data, 0);
      chk({tag, "_out_ch"},    out_ch, 0);
      chk({tag, "_last_ch"},   out_last_ch, 0);
      chk({tag, "_last_fr"},   out_last_frame, 0);
      chk({tag, "_err"},       err, 0);
   endtask

   // Output monitor / consumer: acts only on falling edges.
   initial begin
      bit          prev_stall;
      bit          prev_valid;
      logic        r;
      logic [31:0] sv_data;
      logic [1:0]  sv_ch;
      logic        sv_lc;
      logic        sv_lf;
      beat_t       e;
      prev_stall = 0;
      prev_valid = 0;
      forever begin
         @(negedge clk);
         if (!res_n) begin
            prev_stall = 0;
            prev_valid = 0;
         end else begin
            if (!out_valid) idle_cnt++;
            if (out_valid && !prev_valid) first_valid_cyc = cyc;
            if (prev_stall) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_data", out_data, sv_data);
               chk("hold_ch", out_ch, sv_ch);
               chk("hold_last_ch", out_last_ch, sv_lc);
               chk("hold_last_fr", out_last_frame, sv_lf);
            end
            case (cons_mode)
               0:       r = 1'b0;
               1:       r = 1'b1;
               2:       r = !out_ready;
               default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (out_valid && r) begin
               out_hs_cnt++;
               if (out_hs_cnt == 8) hs8_cyc = cyc + 1;
               if (expq.size() == 0) begin
                  chk("extra_beat", 64'(expq.size()), 1);
               end else begin
                  e = expq.pop_front();
                  chk("out_data", out_data, e.data);
                  chk("out_ch", out_ch, 64'(e.ch));
                  chk("out_last_ch", out_last_ch, e.lc);
                  chk("out_last_frame", out_last_frame, e.lf);
               end
            end
            prev_stall = out_valid && !r;
            prev_valid = out_valid;
            sv_data = out_data;
            sv_ch   = out_ch;
            sv_lc   = out_last_ch;
            sv_lf   = out_last_frame;
         end
      end
   end

   initial begin
      bit seen;
      res_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      out_ready = 1'b0;
      cons_mode = 0;
      repeat (3) @(negedge clk);
      #2;
      check_reset_outputs("rst");
      @(negedge clk);
      #3 res_n = 1'b1;
      @(negedge clk);

      // single frame, pattern data, latency
      cons_mode = 1;
      prod_busy = 1;
      put_beats(BEATS_IN, 0, 8'h80);
      wait_drain();
      chk("latency", 64'(first_valid_cyc - last_acc_cyc), 2);
      chk("err_frame1", err, err_exp);

      // saturation / rounding corner values
      prod_busy = 1;
      put_beats(BEATS_IN, 2, 8'h80);
      wait_drain();

      // random data, random consumer
      cons_mode = 3;
      prod_busy = 1;
      fork put_beats(3*BEATS_IN, 1, 8'h80); join_none
      wait_drain();

      // backpressure with three back-to-back frames
      cons_mode = 0;
      in_hs_cnt = 0;
      out_hs_cnt = 0;
      ready_rise_cyc = -1;
      rdy_prev = 1;
      prod_busy = 1;
      fork put_beats(3*BEATS_IN, 1, 8'h80); join_none
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         #2;
         if (in_hs_cnt >= 2*BEATS_IN) seen = 1;
      end
      if (!seen) chk("bp_fill_timeout", 64'(in_hs_cnt), 2*BEATS_IN);
      chk("bp_in_ready_low", in_ready, 0);
      repeat (4) @(negedge clk);
      #2;
      chk("bp_stalled_count", 64'(in_hs_cnt), 2*BEATS_IN);
      cons_mode = 1;
      wait_drain();
      chk("bp_ready_return", 64'(ready_rise_cyc), 64'(hs8_cyc));
      chk("bp_out_count", 64'(out_hs_cnt), 3*BEATS_IN);

      // alternating out_ready across two back-to-back frames
      cons_mode = 2;
      prod_busy = 1;
      fork put_beats(2*BEATS_IN, 1, 8'h80); join_none
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         #2;
         if (out_valid) seen = 1;
      end
      if (!seen) chk("stall_valid_timeout", out_valid, 1);
      idle_cnt = 0;
      seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         #2;
         if (!prod_busy && expq.size() == 0) seen = 1;
      end
      chk("stall_no_gap", 64'(idle_cnt), 0);
      wait_drain();

      // in_last on beat 5, missing on beat 8
      cons_mode = 1;
      prod_busy = 1;
      put_beats(4, 0, 8'h10);
      chk("err_before", err, err_exp);
      prod_busy = 1;
      put_beats(1, 0, 8'h10);
      chk("err_after5", err, err_exp);
      prod_busy = 1;
      put_beats(3, 0, 8'h10);
      wait_drain();
      chk("err_sticky", err, err_exp);

      // reset with one undrained frame and a partial frame in flight
      cons_mode = 0;
      prod_busy = 1;
      put_beats(BEATS_IN, 1, 8'h80);
      prod_busy = 1;
      put_beats(3, 1, 8'h80);
      #3 res_n = 1'b0;
      #2;
      check_reset_outputs("midrst");
      expq.delete();
      pos = 0;
      err_exp = 0;
      @(negedge clk);
      #3 res_n = 1'b1;
      repeat (4) @(negedge clk);
      #2;
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_ready", in_ready, 1);
      cons_mode = 1;
      prod_busy = 1;
      put_beats(BEATS_IN, 0, 8'h80);
      wait_drain();
      chk("post_rst_latency", 64'(first_valid_cyc - last_acc_cyc), 2);
      chk("post_rst_err", err, err_exp);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
